priority_encoder_handshake: RTL



---
 rtl/priority_encoder_handshake.sv | 109 ++++++++++
 1 files changed

// File: rtl/priority_encoder_handshake.sv
// Registered priority encoder with sticky pending capture and a valid/ready index port.
// Define PRIORITY_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module priority_encoder_handshake #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [INPUT_WIDTH-1:0]  req_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_index,
  output logic                    out_any,
  output logic [INPUT_WIDTH-1:0]  pending
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                  state, state_next;
  logic                    handshake;
  logic                    valid_next;
  logic [INPUT_WIDTH-1:0]  clr_mask, pending_next;
  logic [OUTPUT_WIDTH-1:0] sel_index, index_next;

  assign handshake    = out_valid & out_ready;
  assign clr_mask     = handshake ? (INPUT_WIDTH'(1) << out_index) : '0;
  // A request landing on the bit being cleared is a new event, so set wins.
  assign pending_next = (pending & ~clr_mask) | req_in;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [OUTPUT_WIDTH-1:0] last_grant;

  // Offsets scanned high to low so the nearest one above last_grant wins;
  // offset INPUT_WIDTH lands on last_grant itself, giving it the lowest rank.
  function automatic logic [OUTPUT_WIDTH-1:0] pick(input logic [INPUT_WIDTH-1:0] pend,
                                                   input logic [OUTPUT_WIDTH-1:0] last);
    logic [OUTPUT_WIDTH-1:0] idx;
    int j;
    idx = '0;
    for (int k = INPUT_WIDTH; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= INPUT_WIDTH) j = j - INPUT_WIDTH;
      if (pend[j]) idx = OUTPUT_WIDTH'(j);
    end
    return idx;
  endfunction

  assign sel_index = pick(pending, last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_grant <= '0;
    else if (handshake) last_grant <= out_index;
  end
`else
  function automatic logic [OUTPUT_WIDTH-1:0] pick(input logic [INPUT_WIDTH-1:0] pend);
    logic [OUTPUT_WIDTH-1:0] idx;
    idx = '0;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--)
      if (pend[i]) idx = OUTPUT_WIDTH'(i);
    return idx;
  endfunction

  assign sel_index = pick(pending);
`endif

  always_comb begin
    state_next = state;
    valid_next = out_valid;
    index_next = out_index;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (enable && (pending != '0)) begin
          state_next = PRESENT;
          valid_next = 1'b1;
          index_next = sel_index;
        end
      end
      PRESENT: begin
        if (handshake) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= '0;
      pending   <= '0;
      out_any   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= valid_next;
      out_index <= index_next;
      pending   <= pending_next;
      out_any   <= |pending_next;
    end
  end

endmodule
